wash_cycle_timer: RTL and testbench



---
 rtl/wash_cycle_timer_pkg.sv | 58 +++++
 rtl/wash_cycle_timer_tick_gen.sv | 46 ++++
 rtl/wash_cycle_timer.sv | 121 ++++++++++++
 tb/tb_wash_cycle_timer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_cycle_timer_pkg.sv
// Shared definitions for the wash-cycle phase timer.
//   - phase_e      : 4-bit phase codes, IDLE..SPIN
//   - *_DEF        : default phase durations (seconds), tick divider and counter width
//   - next_phase() : phase sequence IDLE->FILL1->...->SPIN->IDLE
//   - flag_of()    : done-flag vector for a phase, bit order {Ts,Tr,Td,Tw,Tf}
package wash_cycle_timer_pkg;

   typedef enum logic [3:0] {
      PH_IDLE   = 4'd0,
      PH_FILL1  = 4'd1,
      PH_WASH   = 4'd2,
      PH_DRAIN1 = 4'd3,
      PH_FILL2  = 4'd4,
      PH_RINSE  = 4'd5,
      PH_DRAIN2 = 4'd6,
      PH_SPIN   = 4'd7
   } phase_e;

   localparam int TICK_DIV_DEF  = 50000000;
   localparam int FILL_SEC_DEF  = 60;
   localparam int WASH_SEC_DEF  = 300;
   localparam int DRAIN_SEC_DEF = 45;
   localparam int RINSE_SEC_DEF = 180;
   localparam int SPIN_SEC_DEF  = 120;
   localparam int CW_DEF        = 10;

   localparam int FLG_F = 0;
   localparam int FLG_W = 1;
   localparam int FLG_D = 2;
   localparam int FLG_R = 3;
   localparam int FLG_S = 4;

   function automatic phase_e next_phase(input phase_e p);
      case (p)
         PH_IDLE:   next_phase = PH_FILL1;
         PH_FILL1:  next_phase = PH_WASH;
         PH_WASH:   next_phase = PH_DRAIN1;
         PH_DRAIN1: next_phase = PH_FILL2;
         PH_FILL2:  next_phase = PH_RINSE;
         PH_RINSE:  next_phase = PH_DRAIN2;
         PH_DRAIN2: next_phase = PH_SPIN;
         default:   next_phase = PH_IDLE;
      endcase
   endfunction

   function automatic logic [4:0] flag_of(input phase_e p);
      flag_of = 5'b00000;
      case (p)
         PH_FILL1, PH_FILL2:   flag_of[FLG_F] = 1'b1;
         PH_WASH:              flag_of[FLG_W] = 1'b1;
         PH_DRAIN1, PH_DRAIN2: flag_of[FLG_D] = 1'b1;
         PH_RINSE:             flag_of[FLG_R] = 1'b1;
         PH_SPIN:              flag_of[FLG_S] = 1'b1;
         default:              flag_of = 5'b00000;
      endcase
   endfunction

endpackage

// File: rtl/wash_cycle_timer_tick_gen.sv
// One-second tick prescaler for the wash-cycle timer.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   en       in  count enable (phase active and not paused)
//   restart  in  clears the prescaler so the next second is a full TICK_DIV cycles
//   tick     out one-cycle pulse on the last prescaler count while enabled
module wash_tick_gen #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic restart,
   output logic tick
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] cnt_q, cnt_d;
   logic          at_last;

   assign at_last = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (restart) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = at_last ? '0 : cnt_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A restart in the same cycle swallows the tick.
   assign tick = en & at_last & ~restart;

endmodule

// File: rtl/wash_cycle_timer.sv
// Phase-duration timer for the washing-machine controller.
// Tracks the controller's phase via restart pulses R, counts each phase's
// programmed duration in seconds and raises the matching done flag.
// Ports:
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset
//   R          in  restart pulse; each high cycle advances one phase
//   pause      in  freezes prescaler and seconds counter
//   clear      in  synchronous abort to IDLE (beats R and pause)
//   Tf/Tw/Td/Tr/Ts out registered done flags (fill/wash/drain/rinse/spin)
//   phase      out current phase code
//   remaining  out seconds left in the current phase
//
// state  | meaning
// IDLE   | no cycle running, no counting, remaining=0
// FILL1  | first fill, FILL_SEC
// WASH   | wash, WASH_SEC
// DRAIN1 | first drain, DRAIN_SEC
// FILL2  | second fill, FILL_SEC
// RINSE  | rinse, RINSE_SEC
// DRAIN2 | second drain, DRAIN_SEC
// SPIN   | spin, SPIN_SEC
module wash_cycle_timer
   import wash_cycle_timer_pkg::*;
#(
   parameter int TICK_DIV  = TICK_DIV_DEF,
   parameter int FILL_SEC  = FILL_SEC_DEF,
   parameter int WASH_SEC  = WASH_SEC_DEF,
   parameter int DRAIN_SEC = DRAIN_SEC_DEF,
   parameter int RINSE_SEC = RINSE_SEC_DEF,
   parameter int SPIN_SEC  = SPIN_SEC_DEF,
   parameter int CW        = CW_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          R,
   input  logic          pause,
   input  logic          clear,
   output logic          Tf,
   output logic          Tw,
   output logic          Td,
   output logic          Tr,
   output logic          Ts,
   output logic [3:0]    phase,
   output logic [CW-1:0] remaining
);

   phase_e        phase_q, phase_d;
   logic [CW-1:0] rem_q, rem_d;
   logic [4:0]    flags_q, flags_d;
   logic          tick;
   logic          tick_en;

   function automatic logic [CW-1:0] dur_of(input phase_e p);
      case (p)
         PH_FILL1, PH_FILL2:   dur_of = CW'(FILL_SEC);
         PH_WASH:              dur_of = CW'(WASH_SEC);
         PH_DRAIN1, PH_DRAIN2: dur_of = CW'(DRAIN_SEC);
         PH_RINSE:             dur_of = CW'(RINSE_SEC);
         PH_SPIN:              dur_of = CW'(SPIN_SEC);
         default:              dur_of = '0;
      endcase
   endfunction

   assign tick_en = (phase_q != PH_IDLE) && !pause;

   wash_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (tick_en),
      .restart (R | clear),
      .tick    (tick)
   );

   always_comb begin
      phase_d = phase_q;
      rem_d   = rem_q;
      flags_d = flags_q;
      if (clear) begin
         phase_d = PH_IDLE;
         rem_d   = '0;
         flags_d = '0;
      end else if (R) begin
         phase_d = next_phase(phase_q);
         rem_d   = dur_of(phase_d);
         flags_d = '0;
      end else if (phase_q != PH_IDLE) begin
         if (tick && (rem_q != '0)) begin
            rem_d = rem_q - CW'(1);
         end
         // Flag is set on the edge remaining reaches zero; a zero-length
         // phase therefore flags on the first edge after entry.
         if (rem_d == '0) begin
            flags_d = flag_of(phase_q);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= PH_IDLE;
         rem_q   <= '0;
         flags_q <= '0;
      end else begin
         phase_q <= phase_d;
         rem_q   <= rem_d;
         flags_q <= flags_d;
      end
   end

   assign phase     = phase_q;
   assign remaining = rem_q;
   assign Tf        = flags_q[FLG_F];
   assign Tw        = flags_q[FLG_W];
   assign Td        = flags_q[FLG_D];
   assign Tr        = flags_q[FLG_R];
   assign Ts        = flags_q[FLG_S];

endmodule

// File: tb/tb_wash_cycle_timer.sv
module tb_wash_cycle_timer;

   localparam int TD = 4;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          R_i = 1'b0;
   logic          pause_i = 1'b0;
   logic          clear_i = 1'b0;
   logic          Tf, Tw, Td, Tr, Ts;
   logic [3:0]    phase;
   logic [CW-1:0] remaining;
   logic [4:0]    flags_o;

   int checks = 0;
   int errors = 0;

   // Reference model: phase number, active (unpaused) cycles and total
   // cycles spent in the current phase.
   int m_phase = 0;
   int m_active = 0;
   int m_edges = 0;

   assign flags_o = {Ts, Tr, Td, Tw, Tf};

   wash_cycle_timer #(
      .TICK_DIV  (TD),
      .FILL_SEC  (3),
      .WASH_SEC  (5),
      .DRAIN_SEC (2),
      .RINSE_SEC (4),
      .SPIN_SEC  (3),
      .CW        (CW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .R         (R_i),
      .pause     (pause_i),
      .clear     (clear_i),
      .Tf        (Tf),
      .Tw        (Tw),
      .Td        (Td),
      .Tr        (Tr),
      .Ts        (Ts),
      .phase     (phase),
      .remaining (remaining)
   );

   always #5 clk = ~clk;

   function automatic int dur(input int ph);
      case (ph)
         1, 4:    return 3;
         2:       return 5;
         3, 6:    return 2;
         5:       return 4;
         7:       return 3;
         default: return 0;
      endcase
   endfunction

   function automatic int exp_rem();
      int r;
      if (m_phase == 0) return 0;
      r = dur(m_phase) - (m_active / TD);
      return (r < 0) ? 0 : r;
   endfunction

   function automatic int exp_flags();
      if (m_phase == 0 || exp_rem() != 0 || m_edges < 1) return 0;
      case (m_phase)
         1, 4:    return 5'b00001;
         2:       return 5'b00010;
         3, 6:    return 5'b00100;
         5:       return 5'b01000;
         default: return 5'b10000;
      endcase
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("phase", int'(phase), m_phase);
      chk("remaining", int'(remaining), exp_rem());
      chk("flags", int'(flags_o), exp_flags());
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_active = 0;
      m_edges = 0;
   endtask

   task automatic cyc(input logic r, input logic p, input logic c);
      R_i = r;
      pause_i = p;
      clear_i = c;
      @(posedge clk);
      if (!reset_n || c) begin
         model_reset();
      end else if (r) begin
         m_phase = (m_phase + 1) % 8;
         m_active = 0;
         m_edges = 0;
      end else if (m_phase != 0) begin
         m_edges++;
         if (!p) m_active++;
      end
      #1;
      check_all();
      R_i = 1'b0;
      pause_i = 1'b0;
      clear_i = 1'b0;
   endtask

   task automatic wait_flag(output int n);
      n = 0;
      while (flags_o == 5'b0 && n < 200) begin
         cyc(1'b0, 1'b0, 1'b0);
         n++;
      end
      checks++;
      assert (n < 200) else begin
         errors++;
         $error("FAIL wait_flag: timed out after %0d cycles in phase %0d", n, m_phase);
      end
   endtask

   task automatic run_to(input int target);
      int n;
      int guard;
      guard = 0;
      while (m_phase != target && guard < 16) begin
         if (m_phase != 0) wait_flag(n);
         cyc(1'b1, 1'b0, 1'b0);
         guard++;
      end
   endtask

   initial begin
      int n;
      int order[7] = '{5'b00001, 5'b00010, 5'b00100, 5'b00001, 5'b01000, 5'b00100, 5'b10000};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_phase", int'(phase), 0);
      chk("reset_remaining", int'(remaining), 0);
      chk("reset_flags", int'(flags_o), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // First R: FILL1 with 3 s, Tf after 12 cycles, held until next R.
      cyc(1'b1, 1'b0, 1'b0);
      chk("r1_phase", int'(phase), 1);
      chk("r1_remaining", int'(remaining), 3);
      wait_flag(n);
      chk("tf_latency", n, 12);
      chk("tf_value", int'(Tf), 1);
      cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("tf_hold", int'(Tf), 1);
      cyc(1'b1, 1'b0, 1'b0);

      // Rest of a full cycle, R two cycles after each flag.
      for (int i = 1; i < 7; i++) begin
         wait_flag(n);
         chk("flag_order", int'(flags_o), order[i]);
         cyc(1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 1'b0);
         cyc(1'b1, 1'b0, 1'b0);
      end
      chk("cycle_end_phase", int'(phase), 0);
      chk("cycle_end_remaining", int'(remaining), 0);

      // WASH with a 10-cycle pause mid-second.
      run_to(2);
      repeat (6) cyc(1'b0, 1'b0, 1'b0);
      chk("pre_pause_rem", int'(remaining), 4);
      repeat (10) cyc(1'b0, 1'b1, 1'b0);
      chk("paused_rem", int'(remaining), 4);
      wait_flag(n);
      chk("tw_latency_paused", n + 16, 30);
      chk("tw_value", int'(Tw), 1);

      // RINSE: R on the tick cycle discards the tick.
      run_to(5);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("r_on_tick_phase", int'(phase), 6);
      chk("r_on_tick_rem", int'(remaining), 2);
      wait_flag(n);
      chk("td_latency", n, 8);

      // FILL2 with 2 s left: clear beats R.
      cyc(1'b0, 1'b0, 1'b1);
      run_to(4);
      repeat (4) cyc(1'b0, 1'b0, 1'b0);
      chk("fill2_rem", int'(remaining), 2);
      cyc(1'b1, 1'b0, 1'b1);
      chk("clear_phase", int'(phase), 0);
      chk("clear_remaining", int'(remaining), 0);
      chk("clear_flags", int'(flags_o), 0);

      // SPIN: asynchronous reset mid-cycle.
      run_to(7);
      repeat (5) cyc(1'b0, 1'b0, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_phase", int'(phase), 0);
      chk("async_remaining", int'(remaining), 0);
      chk("async_flags", int'(flags_o), 0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      cyc(1'b1, 1'b0, 1'b0);
      chk("post_reset_phase", int'(phase), 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 11) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 99) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
